// File: rtl/bp_cfg_sequencer_if.sv
// ----------------------------------------------------------------------------
// bp_cfg_sequencer_if
//   Configuration write bus between the boot sequencer (master) and the mesh
//   config network (slave).
//   v        master -> slave  write valid
//   ready    slave  -> master write accepted when v & ready
//   core_id  master -> slave  destination core
//   addr     master -> slave  config register address
//   data     master -> slave  config register data (zero-extended)
//   ack      slave  -> master one pulse per completed write (returns a credit)
// ----------------------------------------------------------------------------
interface bp_cfg_sequencer_if #(
  parameter int core_id_w = 1,
  parameter int addr_w    = 16,
  parameter int data_w    = 64
);
  logic                 v;
  logic                 ready;
  logic [core_id_w-1:0] core_id;
  logic [addr_w-1:0]    addr;
  logic [data_w-1:0]    data;
  logic                 ack;

  modport master (output v, core_id, addr, data, input ready, ack);
  modport slave  (input v, core_id, addr, data, output ready, ack);
endinterface

// File: rtl/bp_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// bp_cfg_sequencer
//   Boot-time configuration sequencer for a cc_x_dim_p x cc_y_dim_p mesh.
//   On start_i it writes FREEZE=1, CORE_ID, CORD and DOMAIN to every core in
//   order (x fastest), optionally follows with a FREEZE=0 pass over all cores,
//   waits for every write to be acked and then reports done.
//   Writes are throttled by a credit counter: at most max_credits_p unacked.
//
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   start_i          begin a sequence (ignored while busy_o)
//   auto_unfreeze_i  sampled at start: run the unfreeze pass
//   domain_mask_i    sampled at start: domain mask written to every core
//   cfg              config write bus (master side)
//   busy_o           sequence in progress
//   done_o           sequence complete, held until the next accepted start
//   error_o          sticky: ack received with nothing outstanding
// ----------------------------------------------------------------------------
module bp_cfg_sequencer #(
  parameter int cc_x_dim_p       = 2,
  parameter int cc_y_dim_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int max_credits_p    = 4,
  localparam int num_cores_lp    = cc_x_dim_p * cc_y_dim_p,
  localparam int core_id_w_lp    = (num_cores_lp > 1) ? $clog2(num_cores_lp) : 1,
  localparam int x_w_lp          = (cc_x_dim_p > 1) ? $clog2(cc_x_dim_p) : 1,
  localparam int y_w_lp          = (cc_y_dim_p > 1) ? $clog2(cc_y_dim_p) : 1,
  localparam int credit_w_lp     = $clog2(max_credits_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic                      auto_unfreeze_i,
  input  logic [7:0]                domain_mask_i,
  bp_cfg_sequencer_if.master        cfg,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_UNFRZ,
    S_DRAIN,
    S_DONE
  } state_e;

  // Register indices within one core's CFG burst, in write order.
  typedef enum logic [1:0] {
    R_FREEZE  = 2'd0,
    R_CORE_ID = 2'd1,
    R_CORD    = 2'd2,
    R_DOMAIN  = 2'd3
  } reg_e;

  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp  = cfg_addr_width_p'(16'h0000);
  localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] addr_cord_lp    = cfg_addr_width_p'(16'h0008);
  localparam logic [cfg_addr_width_p-1:0] addr_domain_lp  = cfg_addr_width_p'(16'h000C);

  localparam logic [core_id_w_lp-1:0] last_core_lp = core_id_w_lp'(num_cores_lp - 1);
  localparam logic [x_w_lp-1:0]       last_x_lp    = x_w_lp'(cc_x_dim_p - 1);
  localparam logic [credit_w_lp-1:0]  max_cred_lp  = credit_w_lp'(max_credits_p);

  state_e                  state_q,    state_d;
  logic [core_id_w_lp-1:0] core_q,     core_d;
  logic [x_w_lp-1:0]       x_q,        x_d;
  logic [y_w_lp-1:0]       y_q,        y_d;
  reg_e                    reg_q,      reg_d;
  logic [credit_w_lp-1:0]  cred_q,     cred_d;
  logic [7:0]              mask_q,     mask_d;
  logic                    unfreeze_q, unfreeze_d;
  logic                    error_q,    error_d;

  logic                        issuing;
  logic                        cfg_v;
  logic                        fire;
  logic                        last_core;
  logic [cfg_addr_width_p-1:0] addr;
  logic [cfg_data_width_p-1:0] data;

  // --------------------------------------------------------------------------
  // Handshake and credits
  // --------------------------------------------------------------------------
  // Valid depends only on registered state, never on ready. Since only an
  // accept can raise the credit count, a raised valid stays up (and the
  // payload, which moves only on accept, stays put) until it is taken.
  assign issuing   = (state_q == S_CFG) || (state_q == S_UNFRZ);
  assign cfg_v     = issuing && (cred_q < max_cred_lp);
  assign fire      = cfg_v && cfg.ready;
  assign last_core = (core_q == last_core_lp);

  always_comb begin
    cred_d  = cred_q;
    error_d = error_q;
    if (fire && !cfg.ack) begin
      cred_d = cred_q + credit_w_lp'(1);
    end else if (!fire && cfg.ack) begin
      // An ack with nothing in flight is a protocol error; the counter
      // saturates at zero rather than wrapping.
      if (cred_q != '0) cred_d = cred_q - credit_w_lp'(1);
      else              error_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Payload
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    addr = addr_freeze_lp;
    data = '0;
    if (state_q == S_CFG) begin
      unique case (reg_q)
        R_FREEZE: begin
          addr    = addr_freeze_lp;
          data[0] = 1'b1;
        end
        R_CORE_ID: begin
          addr                    = addr_core_id_lp;
          data[core_id_w_lp-1:0]  = core_q;
        end
        R_CORD: begin
          addr                          = addr_cord_lp;
          data[x_w_lp+y_w_lp-1:0]       = {y_q, x_q};
        end
        R_DOMAIN: begin
          addr      = addr_domain_lp;
          data[7:0] = mask_q;
        end
        default: ;
      endcase
    end
    // The unfreeze pass writes FREEZE with data 0, which the defaults give.
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    core_d     = core_q;
    x_d        = x_q;
    y_d        = y_q;
    reg_d      = reg_q;
    mask_d     = mask_q;
    unfreeze_d = unfreeze_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_CFG;
          mask_d     = domain_mask_i;
          unfreeze_d = auto_unfreeze_i;
          core_d     = '0;
          x_d        = '0;
          y_d        = '0;
          reg_d      = R_FREEZE;
        end
      end

      S_CFG, S_UNFRZ: begin
        // A core is finished on its DOMAIN write in CFG, or on its single
        // FREEZE=0 write in UNFRZ.
        if (fire && ((state_q == S_UNFRZ) || (reg_q == R_DOMAIN))) begin
          reg_d = R_FREEZE;
          if (last_core) begin
            core_d  = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = (state_q == S_CFG && unfreeze_q) ? S_UNFRZ : S_DRAIN;
          end else begin
            core_d = core_q + core_id_w_lp'(1);
            // x/y follow the linear core index as wrap counters.
            if (x_q == last_x_lp) begin
              x_d = '0;
              y_d = y_q + y_w_lp'(1);
            end else begin
              x_d = x_q + x_w_lp'(1);
            end
          end
        end else if (fire) begin
          reg_d = reg_e'(reg_q + 2'd1);
        end
      end

      S_DRAIN: begin
        if (cred_q == '0) state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      core_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      reg_q      <= R_FREEZE;
      cred_q     <= '0;
      mask_q     <= '0;
      unfreeze_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_q     <= core_d;
      x_q        <= x_d;
      y_q        <= y_d;
      reg_q      <= reg_d;
      cred_q     <= cred_d;
      mask_q     <= mask_d;
      unfreeze_q <= unfreeze_d;
      error_q    <= error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cfg.v       = cfg_v;
  assign cfg.core_id = core_q;
  assign cfg.addr    = addr;
  assign cfg.data    = data;

  assign busy_o  = issuing || (state_q == S_DRAIN);
  assign done_o  = (state_q == S_DONE);
  assign error_o = error_q;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bp_cfg_sequencer
//   Scoreboard bench for bp_cfg_sequencer on a 3x2 mesh with 2 credits.
//   The stimulus thread pushes the full expected write list for each accepted
//   start; a monitor on the falling edge pops and compares every accepted
//   write, tracks outstanding credits and the sticky error flag, and checks
//   valid and payload stability every cycle. A driver thread randomises ready
//   and returns acks for accepted writes.
// ----------------------------------------------------------------------------
module tb_bp_cfg_sequencer;

  localparam int X    = 3;
  localparam int Y    = 2;
  localparam int N    = X * Y;
  localparam int MAXC = 2;
  localparam int CIDW = (N > 1) ? $clog2(N) : 1;
  localparam int XW   = (X > 1) ? $clog2(X) : 1;

  typedef struct {
    logic [CIDW-1:0] core;
    logic [15:0]     addr;
    logic [63:0]     data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       auto_unf;
  logic [7:0] mask;
  logic       busy;
  logic       done;
  logic       err;

  bp_cfg_sequencer_if #(.core_id_w(CIDW), .addr_w(16), .data_w(64)) cfg_if ();

  bp_cfg_sequencer #(
    .cc_x_dim_p      (X),
    .cc_y_dim_p      (Y),
    .cfg_addr_width_p(16),
    .cfg_data_width_p(64),
    .max_credits_p   (MAXC)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .start_i        (start),
    .auto_unfreeze_i(auto_unf),
    .domain_mask_i  (mask),
    .cfg            (cfg_if),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_cmp  = 0;
  int  n_fail = 0;

  wr_t exp_q[$];
  int  tb_out   = 0;   // model of writes outstanding after the coming edge
  bit  exp_err  = 0;
  int  acc_cnt  = 0;   // accepts seen (monitor)
  int  ack_cnt  = 0;   // acks returned (driver)
  int  ack_grant = 0;
  int  ack_used  = 0;
  int  ready_mode = 1; // 0 low, 1 high, 2 random
  bit  ack_mode   = 1; // 1 random acks, 0 acks only on grant
  bit  spur       = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the full write list for one sequence.
  function automatic void push_seq(input logic [7:0] m, input bit unf);
    wr_t w;
    for (int c = 0; c < N; c++) begin
      int x = c % X;
      int y = c / X;
      w.core = CIDW'(c);
      w.addr = 16'h0000; w.data = 64'd1;                     exp_q.push_back(w);
      w.addr = 16'h0004; w.data = 64'(c);                    exp_q.push_back(w);
      w.addr = 16'h0008; w.data = 64'((y << XW) | x);        exp_q.push_back(w);
      w.addr = 16'h000C; w.data = 64'(m);                    exp_q.push_back(w);
    end
    if (unf) begin
      for (int c = 0; c < N; c++) begin
        w.core = CIDW'(c); w.addr = 16'h0000; w.data = 64'd0;
        exp_q.push_back(w);
      end
    end
  endfunction

  // ---------------------------------------------------------------- driver
  initial begin
    cfg_if.ready = 1'b0;
    cfg_if.ack   = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       cfg_if.ready = 1'b0;
        1:       cfg_if.ready = 1'b1;
        default: cfg_if.ready = ($urandom_range(3) != 0);
      endcase
      cfg_if.ack = 1'b0;
      if (rst_n) begin
        if (spur) begin
          cfg_if.ack = 1'b1;
        end else if (acc_cnt > ack_cnt) begin
          if (ack_used < ack_grant) begin
            cfg_if.ack = 1'b1; ack_used++; ack_cnt++;
          end else if (ack_mode && $urandom_range(2) != 0) begin
            cfg_if.ack = 1'b1; ack_cnt++;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- monitor
  bit              prev_hold = 0;
  logic [CIDW-1:0] prev_core;
  logic [15:0]     prev_addr;
  logic [63:0]     prev_data;

  always @(negedge clk) begin
    bit  fire;
    bit  ack_ok;
    wr_t e;
    if (!rst_n) begin
      exp_q.delete();
      tb_out    = 0;
      exp_err   = 0;
      acc_cnt   = ack_cnt;
      prev_hold = 0;
    end else begin
      fire = cfg_if.v && cfg_if.ready;
      check("cfg_v", 64'(cfg_if.v), 64'((exp_q.size() != 0) && (tb_out < MAXC)));
      check("error_o", 64'(err), 64'(exp_err));
      if (prev_hold) begin
        check("hold_v",    64'(cfg_if.v),       64'd1);
        check("hold_core", 64'(cfg_if.core_id), 64'(prev_core));
        check("hold_addr", 64'(cfg_if.addr),    64'(prev_addr));
        check("hold_data", cfg_if.data,         prev_data);
      end
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(fire), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_core", 64'(cfg_if.core_id), 64'(e.core));
          check("wr_addr", 64'(cfg_if.addr),    64'(e.addr));
          check("wr_data", cfg_if.data,         e.data);
        end
        acc_cnt++;
      end
      ack_ok = cfg_if.ack && (tb_out > 0 || fire);
      if (cfg_if.ack && tb_out == 0 && !fire) exp_err = 1;
      tb_out = tb_out + (fire ? 1 : 0) - (ack_ok ? 1 : 0);
      prev_hold = cfg_if.v && !cfg_if.ready;
      prev_core = cfg_if.core_id;
      prev_addr = cfg_if.addr;
      prev_data = cfg_if.data;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_seq(input bit unf, input logic [7:0] m);
    auto_unf = unf;
    mask     = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    push_seq(m, unf);
    // Inputs change after the start edge; the sampled values must be kept.
    auto_unf = ~unf;
    mask     = 8'($urandom);
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clear", 64'(done), 64'd0);
    check("start_first_v", 64'(cfg_if.v), 64'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      tick();
      k++;
    end
    check("done_reached", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("outstanding_at_done", 64'(tb_out), 64'd0);
  endtask

  initial begin
    int base;
    int k;
    rst_n = 1'b0; start = 1'b0; auto_unf = 1'b0; mask = 8'h00;
    #7;
    check("rst_v", 64'(cfg_if.v), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(err), 64'd0);
    #15 rst_n = 1'b1;
    tick();

    // Spurious ack in IDLE: error set and sticky, nothing else moves.
    spur = 1; tick(); spur = 0;
    tick(); tick();
    check("spur_error", 64'(err), 64'd1);
    check("spur_v", 64'(cfg_if.v), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);

    // Full sequence with unfreeze, always-ready, random acks.
    ready_mode = 1; ack_mode = 1;
    start_seq(1'b1, 8'hA5);
    wait_done();

    // Credit throttling with acks withheld.
    ack_mode = 0;
    base = acc_cnt;
    start_seq(1'b1, 8'h3C);
    repeat (8) tick();
    check("throttle_accepts", 64'(acc_cnt - base), 64'(MAXC));
    check("throttle_v_low", 64'(cfg_if.v), 64'd0);
    ack_grant++;
    repeat (8) tick();
    check("one_ack_one_write", 64'(acc_cnt - base), 64'(MAXC + 1));
    check("one_ack_v_low", 64'(cfg_if.v), 64'd0);
    ready_mode = 0; ack_mode = 1;
    repeat (10) tick();
    check("v_held_ready_low", 64'(cfg_if.v), 64'd1);
    ready_mode = 2;
    wait_done();

    // No unfreeze pass, random ready.
    start_seq(1'b0, 8'h5A);
    wait_done();

    // Start pulsed mid-sequence is ignored; start in DONE restarts.
    start_seq(1'b1, 8'hC3);
    repeat (4) tick();
    auto_unf = 1'b0; mask = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    wait_done();
    start_seq(1'b0, 8'h96);
    wait_done();

    // Randomised sequences.
    for (int i = 0; i < 4; i++) begin
      ready_mode = 2;
      start_seq(1'($urandom), 8'($urandom));
      wait_done();
    end

    // Reset mid-CFG after three writes, then replay from core 0.
    ready_mode = 1;
    base = acc_cnt;
    start_seq(1'b1, 8'h77);
    k = 0;
    while ((acc_cnt - base) < 3 && k < 100) begin
      tick();
      k++;
    end
    check("pre_reset_writes", 64'((acc_cnt - base) >= 3), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_v", 64'(cfg_if.v), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_error", 64'(err), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_seq(1'b1, 8'hE1);
    wait_done();

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
